// File: rtl/layer_mac_sequencer.sv
// Input-beat / neuron sequencer for a fully connected layer.
// Counts beats per neuron, holds mac_ack until consumed, pulses layer_done.
module layer_mac_sequencer #(
    parameter int IN_COUNT     = 4,
    parameter int NEURON_COUNT = 3,
    parameter int IW           = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
    parameter int NW           = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ack,
    output logic          ready,
    output logic          mac_ack,
    input  logic          mac_ready,
    output logic [IW-1:0] in_idx,
    output logic [NW-1:0] neuron_idx,
    output logic          layer_done,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IW-1:0] IN_LAST = IW'(IN_COUNT - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(NEURON_COUNT - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] in_idx_q, in_idx_d;
    logic [NW-1:0] neuron_idx_q, neuron_idx_d;
    logic          ready_q, ready_d;
    logic          mac_ack_q, mac_ack_d;
    logic          layer_done_q, layer_done_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        in_idx_d     = in_idx_q;
        neuron_idx_d = neuron_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = COUNT;
                    in_idx_d     = '0;
                    neuron_idx_d = '0;
                end
            end
            COUNT: begin
                if (ack) begin
                    if (in_idx_q == IN_LAST) begin
                        in_idx_d = '0;
                        state_d  = FIRE;
                    end else begin
                        in_idx_d = in_idx_q + IW'(1);
                    end
                end
            end
            FIRE: begin
                if (mac_ready) begin
                    if (neuron_idx_q == N_LAST) begin
                        neuron_idx_d = '0;
                        state_d      = DONE;
                    end else begin
                        neuron_idx_d = neuron_idx_q + NW'(1);
                        state_d      = COUNT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        ready_d      = (state_d == COUNT);
        mac_ack_d    = (state_d == FIRE);
        layer_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_idx_q     <= '0;
            neuron_idx_q <= '0;
            ready_q      <= 1'b0;
            mac_ack_q    <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_idx_q     <= in_idx_d;
            neuron_idx_q <= neuron_idx_d;
            ready_q      <= ready_d;
            mac_ack_q    <= mac_ack_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
        end
    end

    assign ready      = ready_q;
    assign mac_ack    = mac_ack_q;
    assign layer_done = layer_done_q;
    assign busy       = busy_q;
    assign in_idx     = in_idx_q;
    assign neuron_idx = neuron_idx_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: a default (4x3) and a degenerate (1x1)
// instance share stimulus and are checked against a beat-count model.
module tb_layer_mac_sequencer;

    logic clk = 1'b0;
    logic rst, start, ack, mac_ready;
    always #5 clk = ~clk;

    logic       ready_a, mac_ack_a, layer_done_a, busy_a;
    logic [1:0] in_idx_a, neuron_idx_a;
    logic       ready_b, mac_ack_b, layer_done_b, busy_b;
    logic [0:0] in_idx_b, neuron_idx_b;

    layer_mac_sequencer #(.IN_COUNT(4), .NEURON_COUNT(3)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ack(ack),
        .ready(ready_a), .mac_ack(mac_ack_a), .mac_ready(mac_ready),
        .in_idx(in_idx_a), .neuron_idx(neuron_idx_a),
        .layer_done(layer_done_a), .busy(busy_a)
    );

    layer_mac_sequencer #(.IN_COUNT(1), .NEURON_COUNT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ack(ack),
        .ready(ready_b), .mac_ack(mac_ack_b), .mac_ready(mac_ready),
        .in_idx(in_idx_b), .neuron_idx(neuron_idx_b),
        .layer_done(layer_done_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;
    int ic[2] = '{4, 1};
    int nc[2] = '{3, 1};

    // Pass progress as total beats accepted and neurons consumed.
    typedef struct {
        bit active;
        bit done;
        int beats;
        int neurons;
    } mdl_t;
    mdl_t m[2];

    function automatic bit firing(int k);
        return m[k].active && (m[k].beats == (m[k].neurons + 1) * ic[k]);
    endfunction

    task automatic cmp(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_edge(int k, bit s, bit a, bit mr, bit r);
        if (r) begin
            m[k] = '{0, 0, 0, 0};
        end else if (m[k].done) begin
            m[k].done = 0;
        end else if (!m[k].active) begin
            if (s) m[k] = '{1, 0, 0, 0};
        end else if (firing(k)) begin
            if (mr) begin
                m[k].neurons++;
                if (m[k].neurons == nc[k]) m[k] = '{0, 1, 0, 0};
            end
        end else if (a) begin
            m[k].beats++;
        end
    endtask

    task automatic check_one(int k, logic rd, logic ma, logic ld, logic bs,
                             logic [31:0] ii, logic [31:0] ni);
        cmp("ready", k, 32'(rd), 32'(m[k].active && !firing(k)));
        cmp("mac_ack", k, 32'(ma), 32'(firing(k)));
        cmp("layer_done", k, 32'(ld), 32'(m[k].done));
        cmp("busy", k, 32'(bs), 32'(m[k].active || m[k].done));
        cmp("in_idx", k, ii, 32'(m[k].beats % ic[k]));
        cmp("neuron_idx", k, ni, 32'(m[k].neurons));
    endtask

    task automatic step(bit s, bit a, bit mr, bit r = 0);
        start = s; ack = a; mac_ready = mr; rst = r;
        @(posedge clk);
        model_edge(0, s, a, mr, r);
        model_edge(1, s, a, mr, r);
        #1;
        check_one(0, ready_a, mac_ack_a, layer_done_a, busy_a,
                  32'(in_idx_a), 32'(neuron_idx_a));
        check_one(1, ready_b, mac_ack_b, layer_done_b, busy_b,
                  32'(in_idx_b), 32'(neuron_idx_b));
    endtask

    task automatic timeout(string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    int  n, pulses, beats, acks;
    bit  hit;

    initial begin
        foreach (m[k]) m[k] = '{0, 0, 0, 0};
        start = 0; ack = 0; mac_ready = 0; rst = 1;

        // Reset then idle
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (3) step(0, 1, 1);

        // Full pass, ack and mac_ready tied high
        step(1, 1, 1);
        n = 0; pulses = 0; hit = 0;
        while (n < 40 && !hit) begin
            step(0, 1, 1);
            n++;
            if (mac_ack_a) pulses++;
            if (layer_done_a) hit = 1;
        end
        if (!hit) timeout("full_pass_done");
        cmp("pass_len", 0, 32'(n), 32'(nc[0] * (ic[0] + 1)));
        cmp("mac_pulses", 0, 32'(pulses), 32'(nc[0]));
        step(0, 1, 1);

        // Back-pressure at the first FIRE
        step(1, 1, 0);
        n = 0;
        while (n < 20 && !mac_ack_a) begin step(0, 1, 0); n++; end
        if (!mac_ack_a) timeout("bp_fire");
        n = 1;
        repeat (7) begin step(0, 1, 0); if (mac_ack_a) n++; end
        cmp("bp_hold", 0, 32'(n), 32'd8);
        n = 0;
        while (n < 40 && !layer_done_a) begin step(0, 1, 1); n++; end
        if (!layer_done_a) timeout("bp_done");
        step(0, 0, 0);

        // Gapped input: ack every third cycle
        step(1, 0, 1);
        n = 0; beats = 0; acks = 0;
        while (n < 200 && !layer_done_a) begin
            bit a;
            a = (n % 3 == 0);
            if (a && ready_a) beats++;
            step(0, a, 1);
            n++;
            if (mac_ack_a) begin
                acks++;
                cmp("gap_beats", 0, 32'(beats), 32'(ic[0]));
                beats = 0;
            end
        end
        if (!layer_done_a) timeout("gap_done");
        cmp("gap_acks", 0, 32'(acks), 32'(nc[0]));
        step(0, 0, 0);

        // Ignored inputs: start in COUNT, ack through FIRE and DONE
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (6) step(0, 1, 0);
        n = 0;
        while (n < 40 && !layer_done_a) begin step(1, 1, 1); n++; end
        if (!layer_done_a) timeout("ign_done");
        step(0, 1, 1);

        // Reset mid-pass at neuron 1, beat 2
        step(1, 1, 1);
        n = 0;
        while (n < 40 && !(neuron_idx_a == 2'd1 && in_idx_a == 2'd2)) begin
            step(0, 1, 1); n++;
        end
        if (!(neuron_idx_a == 2'd1 && in_idx_a == 2'd2)) timeout("mid_reach");
        step(0, 1, 1, 1);
        cmp("mid_rst_busy", 0, 32'(busy_a), 32'd0);
        step(0, 1, 1);
        cmp("mid_rst_nodone", 0, 32'(layer_done_a), 32'd0);
        step(1, 1, 1);
        n = 0;
        while (n < 40 && !layer_done_a) begin step(0, 1, 1); n++; end
        if (!layer_done_a) timeout("clean_done");
        cmp("clean_len", 0, 32'(n), 32'(nc[0] * (ic[0] + 1)));

        // Random stimulus
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 6) == 0, $urandom % 2,
                 ($urandom % 3) != 0, ($urandom % 80) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
